if_fetch: RTL and testbench

Instruction-fetch stage of the 32-bit pipeline: owns the fetch PC, reads instruction words over the shared bus as a master through a request/grant/address-strobe/ready handshake, and loads the IF/ID pipeline register that the decoder and ID/EX register consume. It sits directly upstream of the decode stage. It honours the same stall/flush semantics as the ID/EX register. A one-entry buffer lets a fetch complete while the pipeline is stalled.

---
 rtl/if_fetch_pkg.sv | 25 ++
 rtl/if_bus_master.sv | 54 +++++
 rtl/if_fetch.sv | 120 ++++++++++++
 tb/tb_if_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, the NOP word,
// handshake polarity constants and the fetch FSM encoding.
package if_fetch_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0000;

  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_REQ    = 2'd1,
    FETCH_ACCESS = 2'd2
  } fetch_state_e;

  function automatic logic [WORD_ADDR_W-1:0] pc_inc(input logic [WORD_ADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/if_bus_master.sv
// Bus-facing half of the fetch stage: request/grant/strobe FSM and the
// latched access address. Bus outputs decode from registered state only.
module if_bus_master
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_ADDR_W-1:0] req_pc,
  input  logic                   buf_valid,
  input  logic                   buf_valid_nxt,
  output logic                   bus_req_,
  input  logic                   bus_grant_,
  output logic                   bus_as_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  output logic                   done,
  output logic                   in_access,
  output logic [WORD_ADDR_W-1:0] acc_addr,
  output logic [WORD_DATA_W-1:0] rd_data
);

  fetch_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_IDLE;
      acc_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH_REQ && bus_grant_ == ENABLE_)
        acc_addr <= req_pc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE:   if (!buf_valid) state_nxt = FETCH_REQ;
      FETCH_REQ:    if (bus_grant_ == ENABLE_) state_nxt = FETCH_ACCESS;
      FETCH_ACCESS: if (bus_rdy_ == ENABLE_)
                      state_nxt = buf_valid_nxt ? FETCH_IDLE : FETCH_REQ;
      default:      state_nxt = FETCH_IDLE;
    endcase
  end

  assign in_access = (state == FETCH_ACCESS);
  assign bus_req_  = (state == FETCH_REQ || in_access) ? ENABLE_ : DISABLE_;
  assign bus_as_   = in_access ? ENABLE_ : DISABLE_;
  assign bus_addr  = in_access ? acc_addr : '0;
  assign done      = in_access && (bus_rdy_ == ENABLE_);
  assign rd_data   = bus_rd_data;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetch PC, one-entry completed-fetch buffer,
// dead-access tracking and the IF/ID pipeline register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [WORD_ADDR_W-1:0] RESET_PC = 30'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WORD_ADDR_W-1:0] br_addr,
  output logic                   bus_req_,
  input  logic                   bus_grant_,
  output logic                   bus_as_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  output logic [WORD_ADDR_W-1:0] if_pc,
  output logic [WORD_DATA_W-1:0] if_insn,
  output logic                   if_en
);

  logic [WORD_ADDR_W-1:0] fetch_pc;
  logic                   buf_valid, buf_valid_nxt;
  logic [WORD_ADDR_W-1:0] buf_pc;
  logic [WORD_DATA_W-1:0] buf_insn;
  logic                   discard;

  logic                   done, in_access, keep, redirect;
  logic [WORD_ADDR_W-1:0] acc_addr, redir_pc, req_pc;
  logic [WORD_DATA_W-1:0] rd_data;

  assign redirect = !stall && (flush || br_taken);
  assign redir_pc = flush ? new_pc : br_addr;
  // A grant landing on the redirect edge must already fetch the target,
  // otherwise a stale access would start with nothing marking it dead.
  assign req_pc   = redirect ? redir_pc : fetch_pc;
  assign keep     = done && !discard && !redirect;

  always_comb begin
    buf_valid_nxt = buf_valid;
    if (redirect || !stall)
      buf_valid_nxt = 1'b0;
    else if (keep)
      buf_valid_nxt = 1'b1;
  end

  if_bus_master u_bus_master (
    .clk           (clk),
    .reset         (reset),
    .req_pc        (req_pc),
    .buf_valid     (buf_valid),
    .buf_valid_nxt (buf_valid_nxt),
    .bus_req_      (bus_req_),
    .bus_grant_    (bus_grant_),
    .bus_as_       (bus_as_),
    .bus_addr      (bus_addr),
    .bus_rd_data   (bus_rd_data),
    .bus_rdy_      (bus_rdy_),
    .done          (done),
    .in_access     (in_access),
    .acc_addr      (acc_addr),
    .rd_data       (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      buf_valid <= 1'b0;
      discard   <= 1'b0;
      if_en     <= DISABLE;
      if_pc     <= '0;
      if_insn   <= ISA_NOP;
    end else begin
      buf_valid <= buf_valid_nxt;

      // Only a kept completion advances the PC; a dead access must not
      // overwrite the redirect target.
      if (redirect)
        fetch_pc <= redir_pc;
      else if (keep)
        fetch_pc <= pc_inc(acc_addr);

      if (done)
        discard <= 1'b0;
      else if (redirect && in_access)
        discard <= 1'b1;

      if (!stall) begin
        if (redirect) begin
          if_en   <= DISABLE;
          if_pc   <= '0;
          if_insn <= ISA_NOP;
        end else if (buf_valid) begin
          if_en   <= ENABLE;
          if_pc   <= buf_pc;
          if_insn <= buf_insn;
        end else if (keep) begin
          if_en   <= ENABLE;
          if_pc   <= acc_addr;
          if_insn <= rd_data;
        end else begin
          if_en   <= DISABLE;
          if_insn <= ISA_NOP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stall && keep) begin
      buf_pc   <= acc_addr;
      buf_insn <= rd_data;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized
// stall/redirect/reset traffic against an in-order instruction-stream model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [29:0] RST_PC = 30'h0;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken;
  logic [29:0] new_pc, br_addr, bus_addr, if_pc;
  logic        bus_req_, bus_grant_, bus_as_, bus_rdy_, if_en;
  logic [31:0] bus_rd_data, if_insn;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .bus_req_(bus_req_),
    .bus_grant_(bus_grant_), .bus_as_(bus_as_), .bus_addr(bus_addr),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .if_pc(if_pc),
    .if_insn(if_insn), .if_en(if_en)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b00, a} + 32'h100;
  endfunction

  // Reference: next PC of the in-order stream and the last IF/ID contents.
  logic [29:0] exp_pc;
  logic [29:0] last_pc;
  logic [31:0] last_insn;
  logic        last_en;
  int          delivered = 0;

  // Slave model state.
  int          waits_cfg = 0;
  int          cur_w = 0;
  int          cnt = 0;
  logic        rand_grant = 1'b0;

  task automatic cycle();
    logic        p_reset, p_stall, p_flush, p_br, p_rdy, as_prev;
    logic [29:0] p_new, p_bra, addr_prev;
    logic [31:0] r;
    p_reset = reset; p_stall = stall; p_flush = flush; p_br = br_taken;
    p_new = new_pc; p_bra = br_addr; p_rdy = bus_rdy_;
    as_prev = bus_as_; addr_prev = bus_addr;
    @(negedge clk);

    if (p_reset) begin
      check("rst_en", if_en, 0);
      check("rst_pc", if_pc, 0);
      check("rst_insn", if_insn, ISA_NOP);
      check("rst_req", bus_req_, 1);
      check("rst_as", bus_as_, 1);
      check("rst_addr", bus_addr, 0);
      exp_pc = RST_PC;
    end else if (p_stall) begin
      check("stall_en", if_en, last_en);
      check("stall_pc", if_pc, last_pc);
      check("stall_insn", if_insn, last_insn);
    end else if (p_flush || p_br) begin
      check("redir_en", if_en, 0);
      check("redir_pc", if_pc, 0);
      check("redir_insn", if_insn, ISA_NOP);
      exp_pc = p_flush ? p_new : p_bra;
    end else if (if_en) begin
      check("stream_pc", if_pc, exp_pc);
      check("stream_insn", if_insn, mem_word(exp_pc));
      exp_pc = exp_pc + 30'd1;
      delivered++;
    end else begin
      check("bubble_insn", if_insn, ISA_NOP);
      check("bubble_pc", if_pc, last_pc);
    end
    last_pc = if_pc; last_insn = if_insn; last_en = if_en;

    if (!bus_as_) check("as_without_req", bus_req_, 0);
    if (!p_reset && !as_prev && p_rdy) begin
      check("as_held", bus_as_, 0);
      check("addr_stable", bus_addr, addr_prev);
    end

    if (!bus_as_) begin
      if (cnt == 0) cur_w = (waits_cfg < 0) ? int'($urandom_range(0, 3)) : waits_cfg;
      if (cnt == cur_w) begin
        bus_rdy_ = 1'b0; bus_rd_data = mem_word(bus_addr); cnt = 0;
      end else begin
        bus_rdy_ = 1'b1; bus_rd_data = $urandom; cnt++;
      end
    end else begin
      bus_rdy_ = 1'b1; bus_rd_data = $urandom; cnt = 0;
    end
    r = $urandom;
    bus_grant_ = rand_grant ? (r[1:0] == 2'b00) : 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    do begin cycle(); n++; end while (!if_en && n < 100);
    check({tag, "_timeout"}, if_en, 1);
  endtask

  task automatic wait_access(input string tag);
    int n = 0;
    while (!bus_as_ && n < 100) begin cycle(); n++; end
    while (bus_as_ && n < 200) begin cycle(); n++; end
    check({tag, "_timeout"}, bus_as_, 0);
  endtask

  task automatic wait_addr(input logic [29:0] a);
    int n = 0;
    while (!(!bus_as_ && bus_addr == a) && n < 200) begin cycle(); n++; end
    check("addr_reach", bus_addr, a);
  endtask

  initial begin
    logic [31:0] r;
    int first, last_i, np, run;
    logic pe, started;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0; bus_grant_ = 1'b0; bus_rdy_ = 1'b1;
    bus_rd_data = '0; exp_pc = RST_PC; last_pc = '0; last_insn = ISA_NOP; last_en = 1'b0;

    // Reset, then zero-wait slave with grant tied low.
    cycle(); cycle();
    reset = 1'b0;
    first = -1; pe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (first >= 0) check("zw_alternate", if_en, !pe);
      if (if_en && first < 0) begin
        first = i;
        check("zw_first_pc", if_pc, RST_PC);
      end
      pe = if_en;
    end
    check("zw_count", (delivered >= 6), 1);

    // Three wait cycles: four strobe cycles, one instruction per five.
    waits_cfg = 3; np = 0; last_i = 0; run = 0; started = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!bus_as_) run++;
      else begin
        if (started && run > 0) check("ws3_as_len", run, 4);
        run = 0; started = 1'b1;
      end
      if (if_en) begin
        if (np >= 2) check("ws3_spacing", i - last_i, 5);
        last_i = i; np++;
      end
    end

    // Stall across a completion: buffer fills, request held off.
    waits_cfg = 2;
    wait_access("stall");
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k >= 3) check("stall_no_req", bus_req_, 1);
    end
    stall = 1'b0;
    cycle();
    check("buf_first", if_en, 1);

    // Flush while the access to 0x05 is waiting.
    waits_cfg = 6;
    flush = 1'b1; new_pc = 30'h05; cycle(); flush = 1'b0;
    wait_addr(30'h05);
    flush = 1'b1; new_pc = 30'h40; cycle(); flush = 1'b0;
    wait_en("flush40");
    check("flush40_pc", if_pc, 30'h40);

    // Flush wins over br_taken; both ignored under stall.
    waits_cfg = 0;
    flush = 1'b1; br_taken = 1'b1; new_pc = 30'h80; br_addr = 30'h20;
    cycle(); flush = 1'b0; br_taken = 1'b0;
    wait_en("prio");
    check("prio_pc", if_pc, 30'h80);
    stall = 1'b1; flush = 1'b1; br_taken = 1'b1; new_pc = 30'h11; br_addr = 30'h22;
    repeat (3) cycle();
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    wait_en("ign");
    check("ign_redir", (if_pc == 30'h11 || if_pc == 30'h22), 0);

    // Reset in the middle of an access.
    waits_cfg = 3;
    wait_access("rst");
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rst_mid_req", bus_req_, 1);
    check("rst_mid_as", bus_as_, 1);
    check("rst_mid_en", if_en, 0);
    wait_en("rst_first");
    check("rst_first_pc", if_pc, RST_PC);

    // PC wraps modulo 2^30.
    waits_cfg = 0;
    flush = 1'b1; new_pc = 30'h3FFF_FFFF; cycle(); flush = 1'b0;
    wait_en("wrap_a");
    check("wrap_top_pc", if_pc, 30'h3FFF_FFFF);
    wait_en("wrap_b");
    check("wrap_zero_pc", if_pc, 30'h0);

    // Randomized traffic.
    waits_cfg = -1; rand_grant = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      stall    = (r[1:0] == 2'b00);
      flush    = (r[6:2] == 5'd0);
      br_taken = (r[11:7] == 5'd0);
      reset    = (r[18:12] == 7'd0);
      r = $urandom; new_pc = r[29:0];
      r = $urandom; br_addr = r[29:0];
      cycle();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    repeat (20) cycle();
    check("liveness", (delivered > 200), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
